// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer that feeds a phase increment to a DDS core.
// Define SWEEP_BIDIR_EN for an up-then-down (triangle) sweep; the default build is a sawtooth.
module dds_sweep_ctrl #(
  parameter int M = 24,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         repeat_en,
  input  logic [M-1:0] p_start,
  input  logic [M-1:0] p_step,
  input  logic [N-1:0] n_steps,
  input  logic [N-1:0] dwell,
  output logic [M-1:0] P,
  output logic         val_in,
  output logic         ena_ac,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [M-1:0] p_d;
  logic [N-1:0] step_q, step_d;
  logic [N-1:0] dwell_cnt_q, dwell_cnt_d;
  logic         cfg_load;

  logic [M-1:0] p_start_q, p_step_q;
  logic [N-1:0] n_steps_q, dwell_q;
  logic         repeat_q;

`ifdef SWEEP_BIDIR_EN
  logic dir_q, dir_d;  // 0: stepping up, 1: stepping back down
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      P           <= '0;
      step_q      <= '0;
      dwell_cnt_q <= '0;
      val_in      <= 1'b0;
      ena_ac      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SWEEP_BIDIR_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      P           <= p_d;
      step_q      <= step_d;
      dwell_cnt_q <= dwell_cnt_d;
      val_in      <= (state_d == RUN);
      ena_ac      <= (state_d == RUN);
      busy        <= (state_d == RUN);
      done        <= (state_d == DONE);
`ifdef SWEEP_BIDIR_EN
      dir_q       <= dir_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_start_q <= '0;
      p_step_q  <= '0;
      n_steps_q <= '0;
      dwell_q   <= '0;
      repeat_q  <= 1'b0;
    end else if (cfg_load) begin
      p_start_q <= p_start;
      p_step_q  <= p_step;
      n_steps_q <= n_steps;
      dwell_q   <= dwell;
      repeat_q  <= repeat_en;
    end
  end

  always_comb begin
    state_d     = state_q;
    p_d         = P;
    step_d      = step_q;
    dwell_cnt_d = dwell_cnt_q;
    cfg_load    = 1'b0;
`ifdef SWEEP_BIDIR_EN
    dir_d       = dir_q;
`endif
    unique case (state_q)
      IDLE: begin
        p_d         = '0;
        step_d      = '0;
        dwell_cnt_d = '0;
        if (start && !stop) begin
          cfg_load = 1'b1;
          state_d  = RUN;
          p_d      = p_start;
`ifdef SWEEP_BIDIR_EN
          dir_d    = 1'b0;
`endif
        end
      end
      RUN: begin
        if (stop) begin
          state_d     = IDLE;
          p_d         = '0;
          step_d      = '0;
          dwell_cnt_d = '0;
        end else if (dwell_cnt_q != dwell_q) begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end else begin
          dwell_cnt_d = '0;
`ifdef SWEEP_BIDIR_EN
          if (!dir_q && step_q < n_steps_q) begin
            p_d    = P + p_step_q;
            step_d = step_q + 1'b1;
          end else if (!dir_q && n_steps_q != '0) begin
            dir_d  = 1'b1;
            p_d    = P - p_step_q;
            step_d = step_q - 1'b1;
          end else if (dir_q && step_q != '0) begin
            p_d    = P - p_step_q;
            step_d = step_q - 1'b1;
          end else if (repeat_q) begin
            dir_d  = 1'b0;
            p_d    = p_start_q;
            step_d = '0;
          end else begin
            dir_d   = 1'b0;
            state_d = DONE;
            p_d     = '0;
            step_d  = '0;
          end
`else
          if (step_q < n_steps_q) begin
            p_d    = P + p_step_q;
            step_d = step_q + 1'b1;
          end else if (repeat_q) begin
            p_d    = p_start_q;
            step_d = '0;
          end else begin
            state_d = DONE;
            p_d     = '0;
            step_d  = '0;
          end
`endif
        end
      end
      DONE: begin
        state_d     = IDLE;
        p_d         = '0;
        step_d      = '0;
        dwell_cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
        p_d     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: sawtooth timing, wrap, repeat/stop, reset abort, config isolation.
// Define SWEEP_BIDIR_EN to check the triangle sweep variant.
module tb_dds_sweep_ctrl;
  localparam int M = 24;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, repeat_en;
  logic [M-1:0] p_start, p_step;
  logic [N-1:0] n_steps, dwell;
  logic [M-1:0] P;
  logic         val_in, ena_ac, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.M(M), .N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .repeat_en(repeat_en),
    .p_start(p_start), .p_step(p_step), .n_steps(n_steps), .dwell(dwell),
    .P(P), .val_in(val_in), .ena_ac(ena_ac), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] p_exp,
                         input logic run_exp, input logic done_exp);
    chk({tag, ".P"}, {8'h0, P}, p_exp);
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, run_exp});
    chk({tag, ".val_in"}, {31'h0, val_in}, {31'h0, run_exp});
    chk({tag, ".ena_ac"}, {31'h0, ena_ac}, {31'h0, run_exp});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, done_exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [M-1:0] ps, input logic [M-1:0] pst,
                        input logic [N-1:0] ns, input logic [N-1:0] dw, input logic rp);
    p_start = ps; p_step = pst; n_steps = ns; dwell = dw; repeat_en = rp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
    p_start = '0; p_step = '0; n_steps = '0; dwell = '0;
    tick(); tick();
    chk_out("reset", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_out("idle", 32'h0, 1'b0, 1'b0);

    // Four points of two cycles each
    launch(24'h000100, 24'h000010, 16'd3, 16'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("saw%0d", i), 32'h100 + 32'h10 * (i / 2), 1'b1, 1'b0);
      tick();
    end
    chk_out("saw_done", 32'h0, 1'b0, 1'b1);
    tick();
    chk_out("saw_idle", 32'h0, 1'b0, 1'b0);

    // Modular wrap of the phase increment
    launch(24'hFFFFF0, 24'h000020, 16'd1, 16'd0, 1'b0);
    chk_out("wrap0", 32'hFFFFF0, 1'b1, 1'b0);
    tick();
    chk_out("wrap1", 32'h000010, 1'b1, 1'b0);
    tick();
    chk_out("wrap_done", 32'h0, 1'b0, 1'b1);
    tick();

    // Single point held for dwell+1 cycles
    launch(24'h000042, 24'h000001, 16'd0, 16'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("one%0d", i), 32'h42, 1'b1, 1'b0);
      tick();
    end
    chk_out("one_done", 32'h0, 1'b0, 1'b1);
    tick();

    // Repeat mode; a mid-run start with new config must be ignored
    launch(24'd5, 24'd1, 16'd1, 16'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("rep%0d", i), (i % 2 == 0) ? 32'd5 : 32'd6, 1'b1, 1'b0);
      if (i == 2) begin
        p_start = 24'h000099; p_step = 24'h000007; n_steps = 16'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("rep_stop", 32'h0, 1'b0, 1'b0);
    tick();
    chk_out("rep_stop_idle", 32'h0, 1'b0, 1'b0);

    // Asynchronous reset between edges
    launch(24'h000200, 24'h000004, 16'd5, 16'd3, 1'b0);
    tick();
    chk_out("pre_rst", 32'h200, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_out("async_rst", 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    p_start = 24'h000300; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk_out("start_stop", 32'h0, 1'b0, 1'b0);
    launch(24'h000300, 24'h000001, 16'd0, 16'd0, 1'b0);
    chk_out("post_rst_start", 32'h300, 1'b1, 1'b0);
    tick();
    chk_out("post_rst_done", 32'h0, 1'b0, 1'b1);
    tick();

    // Direction-dependent shape for the same configuration
    launch(24'd8, 24'd2, 16'd2, 16'd0, 1'b0);
`ifdef SWEEP_BIDIR_EN
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("tri%0d", i), (i < 3) ? 32'd8 + 32'd2 * i : 32'd8 + 32'd2 * (4 - i),
              1'b1, 1'b0);
      tick();
    end
`else
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("tri%0d", i), 32'd8 + 32'd2 * i, 1'b1, 1'b0);
      tick();
    end
`endif
    chk_out("tri_done", 32'h0, 1'b0, 1'b1);
    tick();
    chk_out("tri_idle", 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
